// File: rtl/frame_buffer_reader.sv
// Display-side frame store reader: fetches the idle buffer from shared SRAM
// into a word FIFO and unpacks 4-bit palette indices on pixel_req.
module frame_buffer_reader #(
  parameter int          WORDS_PER_FRAME = 76800,
  parameter logic [19:0] FRAME1_BASE     = 20'h12C00,
  parameter int          FIFO_DEPTH      = 8,
  parameter int          RD_LAT          = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        even_frame,
  input  logic        frame_start,
  input  logic        pixel_req,
  output logic [3:0]  pixel_data,
  output logic        pixel_valid,
  output logic        underflow,
  output logic        frame_done,
  output logic        sram_req,
  input  logic        sram_grant,
  output logic [19:0] SRAM_ADDRESS,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  input  logic [15:0] Data_from_SRAM
);

  localparam int CW = $clog2(WORDS_PER_FRAME + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam int LW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    READ
  } state_t;

  state_t          state, state_n;
  logic [LW-1:0]   lat_cnt, lat_n;
  logic [CW-1:0]   word_cnt;
  logic            disp_buf;

  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   fifo_cnt;
  logic [1:0]      nib_sel;
  logic [3:0]      nibble;

  logic            inflight;
  logic            capture;
  logic            push;
  logic            pop;
  logic            avail;

  assign inflight = (state != IDLE);
  assign capture  = (state == READ) && (lat_cnt == LW'(1));
  assign push     = capture && !frame_start;
  assign avail    = (fifo_cnt != '0);
  assign pop      = pixel_req && avail &&
                    (nib_sel == 2'd3) && !frame_start;
  assign nibble   = 4'(fifo_mem[rd_ptr] >> {nib_sel, 2'b00});

  assign sram_req     = inflight;
  assign SRAM_OE_N    = (state != READ);
  assign SRAM_WE_N    = 1'b1;
  assign SRAM_ADDRESS = (disp_buf ? FRAME1_BASE : 20'd0)
                      + 20'(word_cnt);

  // The in-flight read holds a reserved slot, so pushes never overflow.
  always_comb begin
    state_n = state;
    lat_n   = lat_cnt;
    if (frame_start) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!frame_done &&
              (fifo_cnt + NW'(inflight)) < NW'(FIFO_DEPTH))
            state_n = REQ;
        end
        REQ: begin
          if (sram_grant) begin
            state_n = READ;
            lat_n   = LW'(RD_LAT);
          end
        end
        READ: begin
          if (capture) state_n = IDLE;
          else         lat_n   = lat_cnt - LW'(1);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_n;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      disp_buf   <= 1'b0;
      word_cnt   <= '0;
      frame_done <= 1'b1;
    end else if (frame_start) begin
      disp_buf   <= even_frame;
      word_cnt   <= '0;
      frame_done <= 1'b0;
    end else if (capture) begin
      word_cnt <= word_cnt + CW'(1);
      if (word_cnt == CW'(WORDS_PER_FRAME - 1))
        frame_done <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= Data_from_SRAM;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (frame_start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_cnt <= fifo_cnt + NW'(1);
      else if (pop && !push)
        fifo_cnt <= fifo_cnt - NW'(1);
    end
  end

  // The FIFO head is unpacked in place; it is popped after its 4th nibble.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      nib_sel     <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      pixel_valid <= pixel_req;
      if (frame_start) begin
        nib_sel    <= '0;
        pixel_data <= '0;
        underflow  <= 1'b0;
      end else if (pixel_req && avail) begin
        pixel_data <= nibble;
        nib_sel    <= nib_sel + 2'd1;
      end else if (pixel_req) begin
        pixel_data <= '0;
        underflow  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Randomized bench for frame_buffer_reader: SRAM model plus a pixel-stream
// scoreboard derived from fetched-word and consumed-pixel counts.
module tb_frame_buffer_reader;

  localparam int          TW   = 40;
  localparam logic [19:0] BASE = 20'h12C00;
  localparam int          LAT  = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        even_frame;
  logic        frame_start;
  logic        pixel_req;
  logic [3:0]  pixel_data;
  logic        pixel_valid;
  logic        underflow;
  logic        frame_done;
  logic        sram_req;
  logic        sram_grant;
  logic [19:0] SRAM_ADDRESS;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic [15:0] Data_from_SRAM;

  frame_buffer_reader #(
    .WORDS_PER_FRAME(TW),
    .FRAME1_BASE    (BASE),
    .FIFO_DEPTH     (8),
    .RD_LAT         (LAT)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .even_frame    (even_frame),
    .frame_start   (frame_start),
    .pixel_req     (pixel_req),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid),
    .underflow     (underflow),
    .frame_done    (frame_done),
    .sram_req      (sram_req),
    .sram_grant    (sram_grant),
    .SRAM_ADDRESS  (SRAM_ADDRESS),
    .SRAM_OE_N     (SRAM_OE_N),
    .SRAM_WE_N     (SRAM_WE_N),
    .Data_from_SRAM(Data_from_SRAM)
  );

  always #5 Clk = ~Clk;

  logic [15:0] seed;
  int          tests = 0;
  int          fails = 0;

  int          n_acc, n_done, k, oe_run;
  logic        mbuf, exp_uf, exp_done;
  logic [19:0] last_addr;

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    if (a == BASE) return 16'hA3C5;
    return 16'(a * 20'd40503) ^ seed;
  endfunction

  always_comb begin
    Data_from_SRAM = 16'h0;
    if (!SRAM_OE_N) Data_from_SRAM = mem_word(SRAM_ADDRESS);
  end

  function automatic logic [3:0] nib(input int idx);
    logic [19:0] a;
    logic [15:0] w;
    a = (mbuf ? BASE : 20'd0) + 20'(idx / 4);
    w = mem_word(a);
    return 4'(w >> (4 * (idx % 4)));
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    n_acc = 0; n_done = 0; k = 0; oe_run = 0;
    mbuf = 1'b0; exp_uf = 1'b0; exp_done = 1'b1;
  endtask

  task automatic tick();
    logic fs, rq, ev, acc, oe_lo, avail_p;
    logic [19:0] ea;
    fs      = frame_start;
    rq      = pixel_req;
    ev      = even_frame;
    oe_lo   = !SRAM_OE_N;
    acc     = sram_req && SRAM_OE_N && sram_grant && !fs;
    avail_p = (n_done * 4 > k);
    if (acc) begin
      ea = (mbuf ? BASE : 20'd0) + 20'(n_acc);
      check("addr", 32'(SRAM_ADDRESS), 32'(ea));
      check("we_n", 32'(SRAM_WE_N), 32'd1);
      check("fifo_room", 32'((n_done - k / 4) < 8), 32'd1);
      last_addr = SRAM_ADDRESS;
      n_acc++;
    end
    @(posedge Clk);
    #1;
    if (fs) begin
      mbuf = ev; n_acc = 0; n_done = 0; k = 0;
      oe_run = 0; exp_uf = 1'b0; exp_done = 1'b0;
    end else if (oe_lo) begin
      oe_run++;
      if (oe_run == LAT) begin
        n_done++;
        oe_run = 0;
        if (n_done == TW) exp_done = 1'b1;
      end
    end else begin
      oe_run = 0;
    end
    check("valid", 32'(pixel_valid), 32'(rq));
    if (rq) begin
      if (fs) begin
        check("pix_fs", 32'(pixel_data), 32'd0);
      end else if (avail_p) begin
        check("pix", 32'(pixel_data), 32'(nib(k)));
        k++;
      end else begin
        check("pix_uf", 32'(pixel_data), 32'd0);
        exp_uf = 1'b1;
      end
    end
    check("underflow", 32'(underflow), 32'(exp_uf));
    check("frame_done", 32'(frame_done), 32'(exp_done));
    if (n_done > TW) check("overfetch", 32'(n_done), 32'(TW));
  endtask

  task automatic start_frame(input logic ev, input logic rq);
    even_frame  = ev;
    frame_start = 1'b1;
    pixel_req   = rq;
    tick();
    frame_start = 1'b0;
    pixel_req   = 1'b0;
  endtask

  initial begin
    logic [3:0] exp4 [4];
    int         seen;
    int         w;
    exp4 = '{4'h5, 4'hC, 4'h3, 4'hA};
    seed = 16'($urandom);
    model_reset();
    last_addr   = '0;
    Reset       = 1'b1;
    even_frame  = 1'b0;
    frame_start = 1'b0;
    pixel_req   = 1'b0;
    sram_grant  = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_data", 32'(pixel_data), 32'd0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_uf", 32'(underflow), 32'd0);
    check("rst_done", 32'(frame_done), 32'd1);
    check("rst_req", 32'(sram_req), 32'd0);
    check("rst_oe", 32'(SRAM_OE_N), 32'd1);
    check("rst_we", 32'(SRAM_WE_N), 32'd1);
    check("rst_addr", 32'(SRAM_ADDRESS), 32'd0);
    Reset = 1'b0;
    repeat (4) tick();
    check("idle_req", 32'(sram_req), 32'd0);

    // Fill from buffer 1 with no pixels drawn.
    sram_grant = 1'b1;
    start_frame(1'b1, 1'b1);
    repeat (60) tick();
    check("fill_words", 32'(n_done), 32'd8);
    check("fill_req", 32'(sram_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pixel_req = 1'b1;
      tick();
      check("a3c5", 32'(pixel_data), 32'(exp4[i]));
    end
    pixel_req = 1'b0;
    repeat (6) tick();
    check("refill_acc", 32'(n_acc), 32'd9);
    check("refill_addr", 32'(last_addr), 32'(BASE + 20'd8));

    // Underflow with the bus withheld, buffer 0.
    sram_grant = 1'b0;
    start_frame(1'b0, 1'b0);
    repeat (3) tick();
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    check("uf_set", 32'(underflow), 32'd1);
    sram_grant = 1'b1;
    for (int c = 0; c < 400; c++) begin
      sram_grant = ($urandom_range(0, 3) != 0);
      pixel_req  = (k < 4 * TW) && ($urandom_range(0, 2) == 0);
      even_frame = 1'($urandom);
      tick();
    end
    pixel_req = 1'b0;
    check("uf_sticky", 32'(underflow), 32'd1);
    start_frame(1'b1, 1'b0);
    check("uf_clear", 32'(underflow), 32'd0);

    // Abort a read in progress, then refetch from buffer 0.
    sram_grant = 1'b1;
    w = 0;
    while (SRAM_OE_N && w < 20) begin
      tick();
      w++;
    end
    check("oe_wait", 32'(SRAM_OE_N), 32'd0);
    start_frame(1'b0, 1'b0);
    check("abort_oe", 32'(SRAM_OE_N), 32'd1);
    check("abort_req", 32'(sram_req), 32'd0);
    repeat (20) tick();
    check("abort_base", 32'(SRAM_ADDRESS) < 32'd9, 32'd1);

    // Whole frame with random grant, request rate and even_frame.
    start_frame(1'b1, 1'b0);
    for (int c = 0; c < 3000 && !(exp_done && k == 4 * TW); c++) begin
      sram_grant = ($urandom_range(0, 3) != 0);
      pixel_req  = (k < 4 * TW) && 1'($urandom);
      even_frame = 1'($urandom);
      tick();
    end
    pixel_req = 1'b0;
    check("frame_pixels", 32'(k), 32'(4 * TW));
    check("frame_words", 32'(n_acc), 32'(TW));
    check("last_addr", 32'(last_addr), 32'(BASE + 20'(TW - 1)));
    sram_grant = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (sram_req) seen++;
    end
    check("no_req_done", 32'(seen), 32'd0);
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    check("drain_uf", 32'(underflow), 32'd1);

    // Asynchronous reset in the middle of a read.
    start_frame(1'b0, 1'b0);
    w = 0;
    while (SRAM_OE_N && w < 20) begin
      tick();
      w++;
    end
    check("oe_wait2", 32'(SRAM_OE_N), 32'd0);
    #2 Reset = 1'b1;
    #1;
    check("arst_oe", 32'(SRAM_OE_N), 32'd1);
    check("arst_req", 32'(sram_req), 32'd0);
    check("arst_done", 32'(frame_done), 32'd1);
    check("arst_addr", 32'(SRAM_ADDRESS), 32'd0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    repeat (5) tick();
    check("post_rst_req", 32'(sram_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
